move_sequencer: RTL

// Initiator side of the 2048 tile-movement interface. Owns the 4x4 board register and converts

---
 rtl/move_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: owns the 4x4 2048 board, turns one debounced button press into one
// move request, commits the mover's result and spawns a new tile in an empty cell.
// Latency: press -> mv_enable_o next cycle; result sampled from MOVE_LAT cycles into WAIT; spawn 1..16 cycles.
// Backpressure: presses are dropped while busy_o is high; a missing mv_ready_i is abandoned after TIMEOUT WAIT cycles.
//
// Ports:
//   clk_i           rising-edge clock
//   rst_ni          asynchronous active-low reset
//   btn_i           debounced level buttons, [3]=LEFT [2]=DOWN [1]=UP [0]=RIGHT
//   moved_matrix_i  board returned by the movement block, [row][col]
//   mv_ready_i      moved_matrix_i is valid
//   direction_o     one-hot direction to the movement block (btn_i encoding)
//   mv_enable_o     single-cycle move request per accepted press
//   board_o         current board, [row][col], cell idx = 4*row + col
//   busy_o          high in every state except IDLE
//   no_move_o       one-cycle pulse: move changed nothing or the mover timed out
//   full_o          no cell of the board is zero
module move_sequencer #(
    parameter int         WIDTH     = 12,
    parameter int         MOVE_LAT  = 1,
    parameter int         TIMEOUT   = 15,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [3:0]                   btn_i,
    input  logic [3:0][3:0][WIDTH-1:0]   moved_matrix_i,
    input  logic                         mv_ready_i,
    output logic [3:0]                   direction_o,
    output logic                         mv_enable_o,
    output logic [3:0][3:0][WIDTH-1:0]   board_o,
    output logic                         busy_o,
    output logic                         no_move_o,
    output logic                         full_o
);

    localparam int                 CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   LAT_C   = CNT_W'(MOVE_LAT);
    // The counter holds the number of WAIT cycles already completed, so the
    // abort decision is taken at the end of the TIMEOUT-th WAIT cycle.
    localparam logic [CNT_W-1:0]   LAST_C  = CNT_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0]   TILE_2  = WIDTH'(2);
    localparam logic [WIDTH-1:0]   TILE_4  = WIDTH'(4);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COMMIT,
        S_SPAWN
    } state_t;

    state_t                        state_q, state_d;
    logic [3:0][3:0][WIDTH-1:0]    board_q, board_d;
    logic [3:0]                    dir_q, dir_d;
    logic [3:0]                    btn_prev_q;
    logic [7:0]                    lfsr_q, lfsr_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0]                    idx_q, idx_d;     // cell currently examined by SPAWN
    logic [3:0]                    scan_q, scan_d;   // cells already examined minus one
    logic                          no_move_q, no_move_d;

    logic                          btn_onehot;
    logic                          press_ok;
    logic [7:0]                    lfsr_next;
    logic [WIDTH-1:0]              spawn_val;
    logic [WIDTH-1:0]              cell_at_idx;

    // A press counts only on a released->pressed edge of exactly one button;
    // chords and held buttons never start a move.
    assign btn_onehot  = (btn_i != 4'b0000) && ((btn_i & (btn_i - 4'd1)) == 4'b0000);
    assign press_ok    = btn_onehot && (btn_prev_q == 4'b0000);

    assign lfsr_next   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign spawn_val   = (lfsr_q[7:4] == 4'hF) ? TILE_4 : TILE_2;
    assign cell_at_idx = board_q[idx_q[3:2]][idx_q[1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_INIT;
            board_q    <= '0;
            dir_q      <= 4'b0000;
            btn_prev_q <= 4'b0000;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            idx_q      <= 4'd0;
            scan_q     <= 4'd0;
            no_move_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            dir_q      <= dir_d;
            btn_prev_q <= btn_i;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            scan_q     <= scan_d;
            no_move_q  <= no_move_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        dir_d     = dir_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        scan_d    = scan_q;
        no_move_d = 1'b0;

        case (state_q)
            S_INIT: begin
                idx_d   = lfsr_q[3:0];
                scan_d  = 4'd0;
                state_d = S_SPAWN;
            end

            S_IDLE: begin
                if (press_ok) begin
                    dir_d   = btn_i;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                lfsr_d  = lfsr_next;
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A result arriving in the last allowed cycle still wins over the abort.
                if ((cnt_q >= LAT_C) && mv_ready_i) begin
                    state_d = S_COMMIT;
                end else if (cnt_q == LAST_C) begin
                    no_move_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_COMMIT: begin
                if (moved_matrix_i != board_q) begin
                    board_d = moved_matrix_i;
                    idx_d   = lfsr_q[3:0];
                    scan_d  = 4'd0;
                    state_d = S_SPAWN;
                end else begin
                    no_move_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end

            S_SPAWN: begin
                if (cell_at_idx == '0) begin
                    board_d[idx_q[3:2]][idx_q[1:0]] = spawn_val;
                    state_d = S_IDLE;
                end else if (scan_q == 4'd15) begin
                    // Every cell occupied: leave the board as committed.
                    state_d = S_IDLE;
                end else begin
                    idx_d  = idx_q + 4'd1;   // wraps mod 16
                    scan_d = scan_q + 4'd1;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase

        // Direction is only meaningful while a move is in flight.
        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            dir_d = 4'b0000;
        end
    end

    always_comb begin
        full_o = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board_q[r][c] == '0) begin
                    full_o = 1'b0;
                end
            end
        end
    end

    assign direction_o = dir_q;
    assign mv_enable_o = (state_q == S_ISSUE);
    assign board_o     = board_q;
    assign busy_o      = (state_q != S_IDLE);
    assign no_move_o   = no_move_q;

endmodule
